iotdf_param: RTL and testbench

IOTDF_PARAM -- requirements
Module: iotdf_param

---
 rtl/iotdf_pkg.sv | 27 ++
 rtl/iotdf_word_asm.sv | 35 +++
 rtl/iotdf_param.sv | 140 ++++++++++++++
 tb/tb_iotdf_param.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iotdf_pkg.sv
// Shared function encodings and unsigned compare helpers for the iotdf block.
package iotdf_pkg;

   // Widest data word supported (WORD_BYTES up to 32).
   localparam int MAX_W = 256;

   typedef enum logic [2:0] {
      FN_NONE    = 3'd0,
      FN_MAX     = 3'd1,
      FN_MIN     = 3'd2,
      FN_AVG     = 3'd3,
      FN_EXTRACT = 3'd4,
      FN_EXCLUDE = 3'd5,
      FN_PKMAX   = 3'd6,
      FN_PKMIN   = 3'd7
   } fn_e;

   // Unsigned compares; callers zero-extend their W-bit words to MAX_W.
   function automatic logic u_gt(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
      return a > b;
   endfunction

   function automatic logic u_lt(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
      return a < b;
   endfunction

endpackage

// File: rtl/iotdf_word_asm.sv
// Byte-to-word shifter: MSB first, word presented combinationally with its last byte.
module iotdf_word_asm #(
   parameter int WORD_BYTES = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      byte_en,
   input  logic [7:0]                byte_in,
   output logic [8*WORD_BYTES-1:0]   word,
   output logic                      word_done,
   output logic                      word_start
);

   localparam int W  = 8 * WORD_BYTES;
   localparam int CW = $clog2(WORD_BYTES);

   logic [CW-1:0]  cnt;
   logic [W-9:0]   part;

   assign word       = {part, byte_in};
   assign word_done  = byte_en && (cnt == CW'(WORD_BYTES - 1));
   assign word_start = (cnt == '0);

   // Shift in accepted bytes and count them, wrapping at the word boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         part <= '0;
      end else if (byte_en) begin
         part <= word[W-9:0];
         cnt  <= word_done ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/iotdf_param.sv
// Streaming IoT data filter: assembles bytes into words and applies a per-round function.
module iotdf_param
   import iotdf_pkg::*;
#(
   parameter int WORD_BYTES = 16,
   parameter int ROUND_LOG2 = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_en,
   input  logic [7:0]                iot_in,
   input  logic [2:0]                fn_sel,
   input  logic [8*WORD_BYTES-1:0]   lo_th,
   input  logic [8*WORD_BYTES-1:0]   hi_th,
   output logic                      busy,
   output logic                      valid,
   output logic [8*WORD_BYTES-1:0]   iot_out
);

   localparam int W  = 8 * WORD_BYTES;
   localparam int SW = W + ROUND_LOG2;

   function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
      return u_gt(MAX_W'(a), MAX_W'(b));
   endfunction

   function automatic logic lt(input logic [W-1:0] a, input logic [W-1:0] b);
      return u_lt(MAX_W'(a), MAX_W'(b));
   endfunction

   logic                    accept;
   logic [W-1:0]            word;
   logic                    word_done;
   logic                    word_start;

   fn_e                     fn_q;
   fn_e                     fn_eff;
   logic [ROUND_LOG2-1:0]   word_cnt;
   logic [W-1:0]            ext;
   logic [SW-1:0]           sum;
   logic [W-1:0]            pk;
   logic                    pk_have;

   logic                    round_start;
   logic                    first_word;
   logic                    last_word;
   logic [W-1:0]            ext_next;
   logic [SW-1:0]           sum_next;
   logic                    in_range;
   logic                    out_range;
   logic                    pk_better;

   assign accept = in_en && !busy;

   iotdf_word_asm #(
      .WORD_BYTES(WORD_BYTES)
   ) u_word_asm (
      .clk        (clk),
      .rst        (rst),
      .byte_en    (accept),
      .byte_in    (iot_in),
      .word       (word),
      .word_done  (word_done),
      .word_start (word_start)
   );

   // Round bookkeeping and next-value datapath for the active function.
   always_comb begin
      round_start = accept && word_start && (word_cnt == '0);
      fn_eff      = round_start ? fn_e'(fn_sel) : fn_q;
      first_word  = word_done && (word_cnt == '0);
      last_word   = word_done && (word_cnt == '1);
      ext_next    = word;
      if (!first_word) begin
         if (fn_eff == FN_MAX || fn_eff == FN_PKMAX)
            ext_next = gt(word, ext) ? word : ext;
         else
            ext_next = lt(word, ext) ? word : ext;
      end
      sum_next  = (first_word ? '0 : sum) + SW'(word);
      in_range  = lt(lo_th, word) && lt(word, hi_th);
      out_range = lt(word, lo_th) || gt(word, hi_th);
      pk_better = !pk_have ||
                  ((fn_eff == FN_PKMAX) ? gt(ext_next, pk) : lt(ext_next, pk));
   end

   // Registered state and outputs; valid and busy are single-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fn_q     <= FN_NONE;
         word_cnt <= '0;
         ext      <= '0;
         sum      <= '0;
         pk       <= '0;
         pk_have  <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         iot_out  <= '0;
      end else begin
         valid <= 1'b0;
         busy  <= last_word;
         // A change of latched function forgets any stored peak.
         if (round_start) begin
            fn_q <= fn_eff;
            if (fn_eff != fn_q) pk_have <= 1'b0;
         end
         if (word_done) begin
            word_cnt <= word_cnt + 1'b1;
            ext      <= ext_next;
            sum      <= sum_next;
            case (fn_eff)
               FN_EXTRACT: if (in_range) begin
                  iot_out <= word;
                  valid   <= 1'b1;
               end
               FN_EXCLUDE: if (out_range) begin
                  iot_out <= word;
                  valid   <= 1'b1;
               end
               FN_MAX, FN_MIN: if (last_word) begin
                  iot_out <= ext_next;
                  valid   <= 1'b1;
               end
               FN_AVG: if (last_word) begin
                  iot_out <= sum_next[SW-1:ROUND_LOG2];
                  valid   <= 1'b1;
               end
               FN_PKMAX, FN_PKMIN: if (last_word && pk_better) begin
                  iot_out <= ext_next;
                  valid   <= 1'b1;
                  pk      <= ext_next;
                  pk_have <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iotdf_param.sv
// Self-checking bench for iotdf_param at default parameters.
module tb_iotdf_param;

   localparam int WB = 16;
   localparam int RL = 3;
   localparam int N  = 8;
   localparam int W  = 8 * WB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_en = 1'b0;
   logic [7:0]    iot_in = '0;
   logic [2:0]    fn_sel = '0;
   logic [W-1:0]  lo_th = '0;
   logic [W-1:0]  hi_th = '0;
   logic          busy;
   logic          valid;
   logic [W-1:0]  iot_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_cyc = 0;

   logic [W-1:0] q_out[$];
   int           q_cyc[$];
   logic [W-1:0] mq[$];

   // Behavioural model state
   logic [W-1:0] m_words[N];
   logic [W-1:0] m_cur = '0;
   int           m_nbytes = 0;
   int           m_nwords = 0;
   int           m_fn = 0;
   bit           m_pk_have = 0;
   logic [W-1:0] m_pk = '0;
   bit           m_busy = 0;
   bit           m_valid = 0;
   logic [W-1:0] m_out = '0;

   iotdf_param #(.WORD_BYTES(WB), .ROUND_LOG2(RL)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_en   (in_en),
      .iot_in  (iot_in),
      .fn_sel  (fn_sel),
      .lo_th   (lo_th),
      .hi_th   (hi_th),
      .busy    (busy),
      .valid   (valid),
      .iot_out (iot_out)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_cur = '0; m_nbytes = 0; m_nwords = 0; m_fn = 0;
      m_pk_have = 0; m_pk = '0;
      m_busy = 0; m_valid = 0; m_out = '0;
   endtask

   task automatic emit(input logic [W-1:0] v);
      m_valid = 1;
      m_out = v;
      mq.push_back(v);
   endtask

   // One clock of the model: inputs seen now determine outputs after the next edge.
   task automatic model_step();
      bit acc;
      logic [W-1:0] w, mx, mn;
      logic [W+7:0] s;
      acc = in_en && !m_busy;
      m_valid = 0;
      m_busy = 0;
      if (!acc) return;
      if (m_nbytes == 0 && m_nwords == 0) begin
         if (int'(fn_sel) != m_fn) m_pk_have = 0;
         m_fn = int'(fn_sel);
      end
      m_cur = (m_cur << 8) | W'(iot_in);
      m_nbytes++;
      if (m_nbytes < WB) return;
      m_nbytes = 0;
      w = m_cur;
      m_words[m_nwords] = w;
      m_nwords++;
      if (m_fn == 4 && lo_th < w && w < hi_th) emit(w);
      if (m_fn == 5 && (w < lo_th || w > hi_th)) emit(w);
      if (m_nwords == N) begin
         m_nwords = 0;
         m_busy = 1;
         mx = m_words[0];
         mn = m_words[0];
         s = '0;
         for (int i = 0; i < N; i++) begin
            if (m_words[i] > mx) mx = m_words[i];
            if (m_words[i] < mn) mn = m_words[i];
            s = s + (W+8)'(m_words[i]);
         end
         case (m_fn)
            1: emit(mx);
            2: emit(mn);
            3: emit(W'(s / N));
            6: if (!m_pk_have || mx > m_pk) begin emit(mx); m_pk = mx; m_pk_have = 1; end
            7: if (!m_pk_have || mn < m_pk) begin emit(mn); m_pk = mn; m_pk_have = 1; end
            default: ;
         endcase
      end
   endtask

   // Compare process: every cycle, mid-period, DUT against model.
   always @(negedge clk) begin
      if (rst) model_reset();
      check("busy", W'(busy), W'(m_busy));
      check("valid", W'(valid), W'(m_valid));
      check("iot_out", iot_out, m_out);
      if (!rst) model_step();
      if (valid) begin
         q_out.push_back(iot_out);
         q_cyc.push_back(cyc);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      in_en = 1'b1;
      iot_in = b;
      last_cyc = cyc;
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int i = WB - 1; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk); #1;
         in_en = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      in_en = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic clear_seen();
      q_out.delete();
      q_cyc.delete();
      mq.delete();
   endtask

   // Literal expectations on observed outputs; t < 0 means timing not pinned.
   task automatic check_seen(input string name, input int n,
                             input logic [W-1:0] v0, input int t0,
                             input logic [W-1:0] v1, input int t1);
      check({name, " dut count"}, W'(q_out.size()), W'(n));
      check({name, " model count"}, W'(mq.size()), W'(n));
      if (n > 0) begin
         check({name, " dut v0"}, (q_out.size() > 0) ? q_out[0] : 'x, v0);
         check({name, " model v0"}, (mq.size() > 0) ? mq[0] : 'x, v0);
         if (t0 >= 0) check({name, " t0"}, W'((q_cyc.size() > 0) ? q_cyc[0] : -1), W'(t0));
      end
      if (n > 1) begin
         check({name, " dut v1"}, (q_out.size() > 1) ? q_out[1] : 'x, v1);
         check({name, " model v1"}, (mq.size() > 1) ? mq[1] : 'x, v1);
         if (t1 >= 0) check({name, " t1"}, W'((q_cyc.size() > 1) ? q_cyc[1] : -1), W'(t1));
      end
      clear_seen();
   endtask

   initial begin : driver
      logic [W-1:0] w8[8];
      int t_a, t_b;
      logic [7:0] r;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset busy", W'(busy), '0);
      check("reset valid", W'(valid), '0);
      check("reset iot_out", iot_out, '0);
      clear_seen();

      // Max over 5,9,3,1,1,1,1,1
      fn_sel = 3'd1;
      w8 = '{W'(5), W'(9), W'(3), W'(1), W'(1), W'(1), W'(1), W'(1)};
      for (int i = 0; i < 8; i++) send_word(w8[i]);
      t_a = last_cyc + 1;
      idle(3);
      check_seen("max", 1, W'(9), t_a, '0, -1);

      // Average without overflow, then 0..7
      fn_sel = 3'd3;
      for (int i = 0; i < 8; i++) send_word('1);
      idle(3);
      check_seen("avg ones", 1, '1, -1, '0, -1);
      for (int i = 0; i < 8; i++) send_word(W'(i));
      idle(3);
      check_seen("avg ramp", 1, W'(3), -1, '0, -1);

      // Extract with strict bounds
      fn_sel = 3'd4;
      lo_th = W'(10);
      hi_th = W'(20);
      send_word(W'(10));
      send_word(W'(11)); t_a = last_cyc + 1;
      send_word(W'(20));
      send_word(W'(19)); t_b = last_cyc + 1;
      for (int i = 0; i < 4; i++) send_word(W'(0));
      idle(3);
      check_seen("extract", 2, W'(11), t_a, W'(19), t_b);

      // Exclude: bounds themselves never emitted
      fn_sel = 3'd5;
      w8 = '{W'(10), W'(9), W'(20), W'(21), W'(15), W'(10), W'(20), W'(12)};
      for (int i = 0; i < 8; i++) send_word(w8[i]);
      idle(3);
      check_seen("exclude", 2, W'(9), -1, W'(21), -1);

      // Peak-max across three rounds: 50, 40, 60
      fn_sel = 3'd6;
      for (int rnd = 0; rnd < 3; rnd++) begin
         for (int i = 0; i < 8; i++)
            send_word((i == 3) ? ((rnd == 0) ? W'(50) : (rnd == 1) ? W'(40) : W'(60)) : W'(i + 5));
         idle(3);
      end
      check_seen("peak", 2, W'(50), -1, W'(60), -1);

      // in_en held across round end: byte during busy is dropped
      fn_sel = 3'd2;
      for (int i = 0; i < 8; i++) send_word(W'(200 + i));
      send_byte(8'hEE);
      for (int i = 0; i < 8; i++) send_word(W'(100 + i));
      idle(3);
      check_seen("busy drop", 2, W'(200), -1, W'(100), -1);

      // Reset mid-round aborts it; next round counts from scratch
      fn_sel = 3'd2;
      send_word(W'(5)); send_word(W'(6)); send_word(W'(7));
      pulse_reset();
      w8 = '{W'(90), W'(35), W'(70), W'(80), W'(45), W'(99), W'(77), W'(66)};
      for (int i = 0; i < 8; i++) send_word(w8[i]);
      idle(3);
      check_seen("reset abort", 1, W'(35), -1, '0, -1);

      // Randomized traffic against the model
      for (int c = 0; c < 6000; c++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 1499) == 0);
         in_en = ($urandom_range(0, 3) != 0);
         r = 8'($urandom_range(0, 7));
         iot_in = (r < 5) ? 8'h00 : (r < 7) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         if ($urandom_range(0, 399) == 0) fn_sel = 3'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            lo_th = W'($urandom_range(0, 3)) << (8 * $urandom_range(0, 3));
            hi_th = W'($urandom_range(1, 3)) << (8 * $urandom_range(1, 5));
         end
      end
      rst = 1'b0;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
